phys_free_list: RTL and testbench

PHYS_FREE_LIST -- requirements
Module: phys_free_list

---
 rtl/parameter_pkg.sv | 10 +
 rtl/phys_free_list_if.sv | 25 ++
 rtl/phys_free_list.sv | 91 +++++++++
 tb/tb_phys_free_list.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/parameter_pkg.sv
// Register-file sizing shared by the free list and the front/back rename tables.
// DEPTH is the number of physical tags not held by architectural state.
package parameter_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int PHY_WIDTH = 6;
  localparam int DEPTH     = PHY_REGS - ARCH_REGS;

endpackage

// File: rtl/phys_free_list_if.sv
// Rename-stage allocation and retire-stage commit signals of the physical free list.
// The rename/retire logic is the master; the free list is the slave.
interface phys_free_list_if #(
  parameter int PHY_WIDTH = parameter_pkg::PHY_WIDTH
);

  logic [1:0]           alloc_req;
  logic                 alloc_ready;
  logic [PHY_WIDTH-1:0] alloc_phy_0;
  logic [PHY_WIDTH-1:0] alloc_phy_1;
  logic [1:0]           commit_valid;
  logic [PHY_WIDTH-1:0] commit_old_phy_0;
  logic [PHY_WIDTH-1:0] commit_old_phy_1;

  modport master (
    output alloc_req, commit_valid, commit_old_phy_0, commit_old_phy_1,
    input  alloc_ready, alloc_phy_0, alloc_phy_1
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_phy_0, commit_old_phy_1,
    output alloc_ready, alloc_phy_0, alloc_phy_1
  );

endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: two allocations and two returns per cycle,
// with a retire-point head so a flush can roll the speculative head back.
module phys_free_list #(
  parameter int ARCH_REGS   = parameter_pkg::ARCH_REGS,
  parameter int PHY_REGS    = parameter_pkg::PHY_REGS,
  parameter int PHY_WIDTH   = parameter_pkg::PHY_WIDTH,
  localparam int DEPTH      = PHY_REGS - ARCH_REGS,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  phys_free_list_if.slave      bus,
  output logic [CNT_WIDTH-1:0] free_count,
  output logic                 err_overflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int SPC_WIDTH = CNT_WIDTH + 1;

  logic [PHY_WIDTH-1:0] entry [DEPTH];
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] retire_head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH-1:0] head_plus1;
  logic [PTR_WIDTH-1:0] tail_plus1;

  logic [1:0]           n_alloc;
  logic [1:0]           n_commit;
  logic [1:0]           n_push;
  logic [SPC_WIDTH-1:0] space;
  logic                 overflow_now;
  logic [PHY_WIDTH-1:0] first_tag;

  assign head_plus1 = head + PTR_WIDTH'(1);
  assign tail_plus1 = tail + PTR_WIDTH'(1);

  // Readiness uses only the registered count; same-cycle returns are not bypassed.
  always_comb begin
    bus.alloc_ready = (free_count >= CNT_WIDTH'(2));
    bus.alloc_phy_0 = entry[head];
    bus.alloc_phy_1 = bus.alloc_req[0] ? entry[head_plus1] : entry[head];
  end

  // Space left after this cycle's grants decides how many returned tags fit.
  always_comb begin
    n_alloc      = 2'd0;
    n_commit     = {1'b0, bus.commit_valid[0]} + {1'b0, bus.commit_valid[1]};
    if (bus.alloc_ready && !flush) begin
      n_alloc = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    end
    space        = SPC_WIDTH'(DEPTH) - ({1'b0, free_count} - SPC_WIDTH'(n_alloc));
    overflow_now = (SPC_WIDTH'(n_commit) > space);
    n_push       = overflow_now ? space[1:0] : n_commit;
    first_tag    = bus.commit_valid[0] ? bus.commit_old_phy_0 : bus.commit_old_phy_1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head         <= '0;
      retire_head  <= '0;
      tail         <= '0;
      free_count   <= CNT_WIDTH'(DEPTH);
      err_overflow <= 1'b0;
    end else begin
      if (n_push != 2'd0) begin
        entry[tail] <= first_tag;
      end
      if (n_push == 2'd2) begin
        entry[tail_plus1] <= bus.commit_old_phy_1;
      end
      tail        <= tail + PTR_WIDTH'(n_push);
      retire_head <= retire_head + PTR_WIDTH'(n_commit);
      // A flush rewinds to the retire point as it stands after this cycle's commits.
      if (flush) begin
        head       <= retire_head + PTR_WIDTH'(n_commit);
        free_count <= CNT_WIDTH'(DEPTH);
      end else begin
        head       <= head + PTR_WIDTH'(n_alloc);
        free_count <= free_count - CNT_WIDTH'(n_alloc) + CNT_WIDTH'(n_push);
      end
      if (overflow_now) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed-vector bench for the physical free list: reset, dual/single allocation,
// stall, commit return, flush recovery, overflow and pointer wrap.
module tb_phys_free_list;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [5:0] free_count;
  logic       err_overflow;

  int compared   = 0;
  int mismatched = 0;

  phys_free_list_if #(.PHY_WIDTH(6)) bus ();

  phys_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .free_count   (free_count),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush                = 1'b0;
    bus.alloc_req        = 2'b00;
    bus.commit_valid     = 2'b00;
    bus.commit_old_phy_0 = 6'd0;
    bus.commit_old_phy_1 = 6'd0;
  endtask

  // Reset while optionally driving every other input active, to exercise priority.
  task automatic apply_reset(input bit busy);
    idle_inputs();
    if (busy) begin
      flush                = 1'b1;
      bus.alloc_req        = 2'b11;
      bus.commit_valid     = 2'b11;
      bus.commit_old_phy_0 = 6'd3;
      bus.commit_old_phy_1 = 6'd4;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    bus.alloc_req = 2'b01;
    #1;
    compared++; if (bus.alloc_phy_0 !== 6'd32) begin mismatched++; $display("[TB] FAIL reset_phy0: got %0d want 32", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd33) begin mismatched++; $display("[TB] FAIL reset_phy1: got %0d want 33", bus.alloc_phy_1); end
    compared++; if (bus.alloc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %0b want 1", bus.alloc_ready); end
    compared++; if (free_count !== 6'd32) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 32", free_count); end
    compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %0b want 0", err_overflow); end
    idle_inputs();
  endtask

  task automatic test_dual_alloc();
    apply_reset(1'b0);
    bus.alloc_req = 2'b11;
    #1;
    compared++; if (bus.alloc_phy_0 !== 6'd32) begin mismatched++; $display("[TB] FAIL dual_phy0: got %0d want 32", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd33) begin mismatched++; $display("[TB] FAIL dual_phy1: got %0d want 33", bus.alloc_phy_1); end
    tick();
    bus.alloc_req = 2'b01;
    #1;
    compared++; if (free_count !== 6'd30) begin mismatched++; $display("[TB] FAIL dual_count: got %0d want 30", free_count); end
    compared++; if (bus.alloc_phy_0 !== 6'd34) begin mismatched++; $display("[TB] FAIL dual_next_phy0: got %0d want 34", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd35) begin mismatched++; $display("[TB] FAIL dual_next_phy1: got %0d want 35", bus.alloc_phy_1); end
    idle_inputs();
  endtask

  // Slot-1-only allocation, drain to one tag, stall, then return tags 5 and 7 across the wrap.
  task automatic test_stall_and_commit();
    apply_reset(1'b0);
    bus.alloc_req = 2'b10;
    #1;
    compared++; if (bus.alloc_phy_1 !== 6'd32) begin mismatched++; $display("[TB] FAIL slot1_phy1: got %0d want 32", bus.alloc_phy_1); end
    tick();
    compared++; if (free_count !== 6'd31) begin mismatched++; $display("[TB] FAIL slot1_count: got %0d want 31", free_count); end
    bus.alloc_req = 2'b11;
    for (int i = 0; i < 15; i++) tick();
    compared++; if (free_count !== 6'd1) begin mismatched++; $display("[TB] FAIL drain_count: got %0d want 1", free_count); end
    compared++; if (bus.alloc_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_ready: got %0b want 0", bus.alloc_ready); end
    for (int i = 0; i < 3; i++) tick();
    compared++; if (free_count !== 6'd1) begin mismatched++; $display("[TB] FAIL stall_count: got %0d want 1", free_count); end
    compared++; if (bus.alloc_phy_0 !== 6'd63) begin mismatched++; $display("[TB] FAIL stall_phy0: got %0d want 63", bus.alloc_phy_0); end
    bus.alloc_req        = 2'b00;
    bus.commit_valid     = 2'b11;
    bus.commit_old_phy_0 = 6'd5;
    bus.commit_old_phy_1 = 6'd7;
    tick();
    idle_inputs();
    #1;
    compared++; if (free_count !== 6'd3) begin mismatched++; $display("[TB] FAIL commit_count: got %0d want 3", free_count); end
    compared++; if (bus.alloc_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL commit_ready: got %0b want 1", bus.alloc_ready); end
    bus.alloc_req = 2'b01;
    #1;
    compared++; if (bus.alloc_phy_0 !== 6'd63) begin mismatched++; $display("[TB] FAIL drain_last_phy0: got %0d want 63", bus.alloc_phy_0); end
    tick();
    bus.alloc_req = 2'b11;
    #1;
    compared++; if (bus.alloc_phy_0 !== 6'd5) begin mismatched++; $display("[TB] FAIL returned_phy0: got %0d want 5", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd7) begin mismatched++; $display("[TB] FAIL returned_phy1: got %0d want 7", bus.alloc_phy_1); end
    tick();
    idle_inputs();
    #1;
    compared++; if (free_count !== 6'd0) begin mismatched++; $display("[TB] FAIL empty_count: got %0d want 0", free_count); end
    compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_err: got %0b want 0", err_overflow); end
  endtask

  task automatic test_flush_recovery();
    apply_reset(1'b0);
    bus.alloc_req = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    bus.alloc_req        = 2'b00;
    bus.commit_valid     = 2'b11;
    bus.commit_old_phy_0 = 6'd10;
    bus.commit_old_phy_1 = 6'd11;
    tick();
    idle_inputs();
    #1;
    compared++; if (free_count !== 6'd28) begin mismatched++; $display("[TB] FAIL preflush_count: got %0d want 28", free_count); end
    flush = 1'b1;
    tick();
    idle_inputs();
    bus.alloc_req = 2'b01;
    #1;
    compared++; if (free_count !== 6'd32) begin mismatched++; $display("[TB] FAIL flush_count: got %0d want 32", free_count); end
    compared++; if (bus.alloc_phy_0 !== 6'd34) begin mismatched++; $display("[TB] FAIL flush_phy0: got %0d want 34", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd35) begin mismatched++; $display("[TB] FAIL flush_phy1: got %0d want 35", bus.alloc_phy_1); end
    idle_inputs();
  endtask

  // Flush, commit and allocate together; the pushed tags must surface after the list drains.
  task automatic test_flush_with_traffic();
    apply_reset(1'b0);
    bus.alloc_req = 2'b11;
    tick();
    tick();
    bus.alloc_req        = 2'b00;
    bus.commit_valid     = 2'b11;
    bus.commit_old_phy_0 = 6'd20;
    bus.commit_old_phy_1 = 6'd21;
    tick();
    flush                = 1'b1;
    bus.alloc_req        = 2'b11;
    bus.commit_old_phy_0 = 6'd22;
    bus.commit_old_phy_1 = 6'd23;
    tick();
    idle_inputs();
    #1;
    compared++; if (free_count !== 6'd32) begin mismatched++; $display("[TB] FAIL flushmix_count: got %0d want 32", free_count); end
    compared++; if (bus.alloc_phy_0 !== 6'd36) begin mismatched++; $display("[TB] FAIL flushmix_phy0: got %0d want 36", bus.alloc_phy_0); end
    compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL flushmix_err: got %0b want 0", err_overflow); end
    bus.alloc_req = 2'b11;
    for (int i = 0; i < 14; i++) tick();
    compared++; if (bus.alloc_phy_0 !== 6'd20) begin mismatched++; $display("[TB] FAIL flushmix_ret0: got %0d want 20", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd21) begin mismatched++; $display("[TB] FAIL flushmix_ret1: got %0d want 21", bus.alloc_phy_1); end
    tick();
    compared++; if (bus.alloc_phy_0 !== 6'd22) begin mismatched++; $display("[TB] FAIL flushmix_ret2: got %0d want 22", bus.alloc_phy_0); end
    compared++; if (bus.alloc_phy_1 !== 6'd23) begin mismatched++; $display("[TB] FAIL flushmix_ret3: got %0d want 23", bus.alloc_phy_1); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    apply_reset(1'b0);
    bus.commit_valid     = 2'b01;
    bus.commit_old_phy_0 = 6'd9;
    tick();
    idle_inputs();
    #1;
    compared++; if (err_overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL overflow_set: got %0b want 1", err_overflow); end
    compared++; if (free_count !== 6'd32) begin mismatched++; $display("[TB] FAIL overflow_count: got %0d want 32", free_count); end
    for (int i = 0; i < 3; i++) tick();
    compared++; if (err_overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL overflow_sticky: got %0b want 1", err_overflow); end
    apply_reset(1'b0);
    #1;
    compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL overflow_cleared: got %0b want 0", err_overflow); end
  endtask

  // Steady single alloc plus single commit for 40 cycles, checked against a FIFO model.
  task automatic test_wrap_fifo();
    int q[$];
    logic [5:0] tag;
    int want;
    apply_reset(1'b0);
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    for (int k = 0; k < 40; k++) begin
      tag                  = 6'((k * 5 + 1) % 64);
      bus.alloc_req        = 2'b01;
      bus.commit_valid     = 2'b01;
      bus.commit_old_phy_0 = tag;
      #1;
      want = q.pop_front();
      q.push_back(int'(tag));
      compared++; if (bus.alloc_phy_0 !== 6'(want)) begin mismatched++; $display("[TB] FAIL wrap_phy0[%0d]: got %0d want %0d", k, bus.alloc_phy_0, want); end
      tick();
    end
    idle_inputs();
    #1;
    compared++; if (free_count !== 6'd32) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d want 32", free_count); end
    compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_err: got %0b want 0", err_overflow); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_dual_alloc();
    test_stall_and_commit();
    test_flush_recovery();
    test_flush_with_traffic();
    test_overflow();
    test_wrap_fifo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
